landing_ctrl: RTL and testbench
===============================

Name: landing_ctrl

Overview:
- Game-level sequencer for the landing-pad overlay stage of the VGA pipeline. Drives landing1_enable and landing2_enable.
- Selects one target pad per round and evaluates the lander position and velocity once per frame.
- Declares touchdown success or crash, blinks the pad on success and keeps a score.
- Runs in the pixel clock domain and uses vsync from the timing generator as the frame tick.

Parameters:
- PAD1_X, 10, left x of pad 1
- PAD2_X, 630, left x of pad 2
- PAD_Y, 560, top y of both pads
- PAD_W, 115, pad width in pixels
- SAFE_VY, 4, maximum vertical speed (px/frame) for a safe landing
- TIMEOUT_FRAMES, 1800, frames allowed per round (only with the optional feature)
- RESULT_FRAMES, 120, frames spent in the RESULT state
- BLINK_SHIFT, 3, blink half-period = 2^BLINK_SHIFT frames

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset: asynchronous, active-high
- vsync_in  in  1  vertical sync from the timing generator
- start  in  1  one-cycle pulse that starts a game; honoured only in IDLE
- lander_x  in  11  lander horizontal centre
- lander_y  in  11  lander bottom edge
- lander_vy  in  8  signed vertical speed, positive = downward
- landing1_enable  out  1  pad 1 visible
- landing2_enable  out  1  pad 2 visible
- target  out  1  active pad: 0 = pad 1, 1 = pad 2
- success  out  1  one-cycle pulse on a good landing
- crash  out  1  one-cycle pulse on a failed landing or timeout
- busy  out  1  high whenever the state is not IDLE
- score  out  8  successful landings, saturating

Behaviour:
- Reset values: state IDLE, both enables 0, target 0, success 0, crash 0, busy 0, score 0, all counters 0, vsync_q 0.
- Frame tick: tick = vsync_in & ~vsync_q, where vsync_q is vsync_in registered on clk. Tick is high for one clk.
- All game evaluation happens only on a tick cycle. Outputs are registered, so an output changes the cycle after the tick.
- IDLE:
  - Both enables are 0.
  - On start: score <= 0, target <= 0, frame_cnt <= 0, go to ACTIVE.
  - start in any other state is ignored.
- ACTIVE:
  - The enable of the target pad is 1 and the other enable is 0.
  - Touch is defined as lander_y >= PAD_Y.
  - Hit is defined as pad_x <= lander_x < pad_x + PAD_W, where pad_x is the x of the target pad. Compare at 12 bits so the sum cannot overflow.
  - Safe is defined as $signed(lander_vy) <= SAFE_VY. Negative speed counts as safe.
  - On a tick with touch & hit & safe: pulse success, score <= score + 1 saturating at 255, go to RESULT with res_ok = 1.
  - On a tick with touch & !(hit & safe): pulse crash, go to RESULT with res_ok = 0.
  - Otherwise, on a tick, frame_cnt increments.
- RESULT:
  - res_cnt counts ticks from 0 up to RESULT_FRAMES-1.
  - If res_ok = 1: the target pad enable = res_cnt[BLINK_SHIFT] and the other pad is 0.
  - If res_ok = 0: both enables are 0.
  - On the tick where res_cnt = RESULT_FRAMES-1:
    - res_ok = 1: target <= ~target, frame_cnt <= 0, go to ACTIVE.
    - res_ok = 0: go to IDLE. Score is held until the next start.
- Simultaneous events:
  - Touch and timeout on the same tick: touch evaluation wins and the timeout is ignored.
  - success and crash are never high together.
- Pulse timing: success and crash are asserted exactly one clk, in the cycle after the deciding tick.
- rst asserted mid-round returns all state to reset values immediately.

Optional Feature:
- Macro: LANDING_TIMEOUT_EN.
- Defined: in ACTIVE, a tick with no touch and frame_cnt = TIMEOUT_FRAMES-1 pulses crash and goes to RESULT with res_ok = 0. frame_cnt is 11 bits wide.
- Not defined: there is no timeout and ACTIVE waits indefinitely. The frame_cnt register and its logic are omitted.

Decomposition:
- Package landing_pkg holds:
  - the pad geometry constants PAD1_X, PAD2_X, PAD_Y, PAD_W, shared with the pad overlay stage so drawing and hit-test can never disagree;
  - the state encoding IDLE = 2'd0, ACTIVE = 2'd1, RESULT = 2'd2.
- One sub-module, frame_tick: the vsync rising-edge detector, with inputs clk/rst/vsync_in and output tick.

Test Plan:
- Reset, then start, then 3 frames with lander_y = 300 -> busy = 1, landing1_enable = 1, landing2_enable = 0, no pulses.
- Touch with lander_y = 560, lander_x = 60, lander_vy = 3 -> success for 1 clk, score = 1, pad 1 blinks with period 16 frames. After 120 frames: target = 1 and landing2_enable = 1.
- On pad 2: touch with lander_x = 700, lander_vy = 5 -> crash, both enables 0 for 120 frames, then IDLE, busy = 0, score held at 1.
- Boundary x on pad 1: lander_x = 124 at touch -> success; repeat with lander_x = 125 -> crash.
- With LANDING_TIMEOUT_EN and TIMEOUT_FRAMES = 10: no touch -> crash on the 10th tick. With touch on that same 10th tick at a valid spot -> success, not crash.
- Assert rst during RESULT -> all outputs 0 asynchronously, then start works normally. A start pulse during ACTIVE leaves score and target unchanged.

Source files
------------

// File: rtl/landing_pkg.sv
// -----------------------------------------------------------------------------
// landing_pkg
// Shared definitions for the landing-pad game logic.
//   - Pad geometry. The pad overlay stage draws from the same constants, so
//     what is drawn and what is hit-tested can never disagree.
//   - Port widths used by the landing_ctrl interface.
//   - Game FSM state encoding.
//   - pad_left(): left x of the selected pad.
// No ports (package).
// -----------------------------------------------------------------------------
package landing_pkg;

    // Port widths
    localparam int X_W     = 11;
    localparam int Y_W     = 11;
    localparam int VY_W    = 8;
    localparam int SCORE_W = 8;

    // Pad geometry. X values are 12 bits so that x + PAD_W cannot overflow.
    localparam logic [11:0] PAD1_X = 12'd10;
    localparam logic [11:0] PAD2_X = 12'd630;
    localparam logic [11:0] PAD_W  = 12'd115;
    localparam logic [10:0] PAD_Y  = 11'd560;

    // Game FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACTIVE = 2'd1;
    localparam state_t RESULT = 2'd2;

    // Left x of the active pad: sel = 0 -> pad 1, sel = 1 -> pad 2.
    function automatic logic [11:0] pad_left(input logic sel);
        return sel ? PAD2_X : PAD1_X;
    endfunction

endpackage

// File: rtl/landing_ctrl_if.sv
// -----------------------------------------------------------------------------
// landing_ctrl_if
// Bundles the game-control signals between the lander/timing logic and
// landing_ctrl.
//   slave  : landing_ctrl side (consumes vsync/start/lander state, drives
//            pad enables, target, pulses, busy and score)
//   master : stimulus/upstream side (the reverse directions)
// Signals:
//   vsync_in        1   vertical sync from the timing generator
//   start           1   one-cycle game start pulse
//   lander_x        11  lander horizontal centre
//   lander_y        11  lander bottom edge
//   lander_vy       8   signed vertical speed, positive = downward
//   landing1_enable 1   pad 1 visible
//   landing2_enable 1   pad 2 visible
//   target          1   active pad (0 = pad 1, 1 = pad 2)
//   success         1   one-cycle pulse on a good landing
//   crash           1   one-cycle pulse on a failed landing or timeout
//   busy            1   game in progress (state not IDLE)
//   score           8   successful landings, saturating
// -----------------------------------------------------------------------------
interface landing_ctrl_if;
    import landing_pkg::*;

    logic               vsync_in;
    logic               start;
    logic [X_W-1:0]     lander_x;
    logic [Y_W-1:0]     lander_y;
    logic [VY_W-1:0]    lander_vy;
    logic               landing1_enable;
    logic               landing2_enable;
    logic               target;
    logic               success;
    logic               crash;
    logic               busy;
    logic [SCORE_W-1:0] score;

    modport slave (
        input  vsync_in, start, lander_x, lander_y, lander_vy,
        output landing1_enable, landing2_enable, target, success, crash,
               busy, score
    );

    modport master (
        output vsync_in, start, lander_x, lander_y, lander_vy,
        input  landing1_enable, landing2_enable, target, success, crash,
               busy, score
    );

endinterface

// File: rtl/landing_ctrl_frame_tick.sv
// -----------------------------------------------------------------------------
// frame_tick
// Rising-edge detector on vsync. Produces a one-clk frame tick in the pixel
// clock domain.
// Ports:
//   clk       in   pixel clock
//   rst       in   asynchronous, active-high reset
//   vsync_in  in   vertical sync from the timing generator
//   tick      out  high for one clk on each vsync rising edge
// -----------------------------------------------------------------------------
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic r_vsync_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_q <= 1'b0;
        end else begin
            r_vsync_q <= vsync_in;
        end
    end

    assign tick = vsync_in & ~r_vsync_q;

endmodule

// File: rtl/landing_ctrl.sv
// -----------------------------------------------------------------------------
// landing_ctrl
// Game-level sequencer for the landing-pad overlay stage. Picks a target pad
// per round, evaluates the lander once per frame (vsync rising edge), declares
// success or crash, blinks the pad after a good landing and keeps a score.
//
// Optional build macro: LANDING_TIMEOUT_EN
//   defined   : a round with no touch for TIMEOUT_FRAMES frames ends in crash.
//   undefined : ACTIVE waits indefinitely; the frame counter is not built.
//
// Parameters:
//   SAFE_VY         max downward speed (px/frame) for a safe landing
//   RESULT_FRAMES   frames spent in RESULT
//   BLINK_SHIFT     blink half-period = 2^BLINK_SHIFT frames
//   TIMEOUT_FRAMES  frames allowed per round (LANDING_TIMEOUT_EN only)
//
// Ports:
//   clk  in   pixel clock
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of landing_ctrl_if (see that file for signal list)
// -----------------------------------------------------------------------------
module landing_ctrl
    import landing_pkg::*;
#(
    parameter int SAFE_VY       = 4,
    parameter int RESULT_FRAMES = 120,
    parameter int BLINK_SHIFT   = 3
`ifdef LANDING_TIMEOUT_EN
    ,
    parameter int TIMEOUT_FRAMES = 1800
`endif
) (
    input  logic           clk,
    input  logic           rst,
    landing_ctrl_if.slave  bus
);

    // res_cnt must reach RESULT_FRAMES-1 and must also own the blink bit.
    localparam int RES_CNT_W = ($clog2(RESULT_FRAMES) > BLINK_SHIFT) ?
                               $clog2(RESULT_FRAMES) : BLINK_SHIFT + 1;
    localparam logic [RES_CNT_W-1:0]   RES_LAST  = RES_CNT_W'(RESULT_FRAMES - 1);
    localparam logic signed [VY_W-1:0] SAFE_VY_S = VY_W'(SAFE_VY);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t               r_state;
    logic                 r_target;
    logic                 r_res_ok;
    logic [RES_CNT_W-1:0] r_res_cnt;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_success;
    logic                 r_crash;
`ifdef LANDING_TIMEOUT_EN
    localparam logic [10:0] FRAME_LAST = 11'(TIMEOUT_FRAMES - 1);
    logic [10:0]          r_frame_cnt;
`endif

    // ---------------------------------------------------------------------
    // Frame tick and landing evaluation
    // ---------------------------------------------------------------------
    logic        w_tick;
    logic        w_touch;
    logic        w_hit;
    logic        w_safe;
    logic [11:0] w_pad_x;
    logic [11:0] w_lx;
    logic        w_en1;
    logic        w_en2;

    frame_tick u_frame_tick (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (bus.vsync_in),
        .tick     (w_tick)
    );

    // Hit-test at 12 bits: pad_x + PAD_W can exceed the 11-bit x range.
    assign w_lx    = {1'b0, bus.lander_x};
    assign w_pad_x = pad_left(r_target);
    assign w_hit   = (w_lx >= w_pad_x) && (w_lx < (w_pad_x + PAD_W));
    assign w_touch = (bus.lander_y >= PAD_Y);
    // Signed compare: any upward (negative) speed is safe.
    assign w_safe  = ($signed(bus.lander_vy) <= SAFE_VY_S);

    // ---------------------------------------------------------------------
    // Game FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_target    <= 1'b0;
            r_res_ok    <= 1'b0;
            r_res_cnt   <= '0;
            r_score     <= '0;
            r_success   <= 1'b0;
            r_crash     <= 1'b0;
`ifdef LANDING_TIMEOUT_EN
            r_frame_cnt <= '0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one clk.
            r_success <= 1'b0;
            r_crash   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_score     <= '0;
                        r_target    <= 1'b0;
`ifdef LANDING_TIMEOUT_EN
                        r_frame_cnt <= '0;
`endif
                        r_state     <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (w_tick) begin
                        // Touch is evaluated first so it wins over a
                        // timeout on the same tick.
                        if (w_touch) begin
                            r_res_cnt <= '0;
                            r_state   <= RESULT;
                            if (w_hit && w_safe) begin
                                r_success <= 1'b1;
                                r_res_ok  <= 1'b1;
                                if (r_score != {SCORE_W{1'b1}}) begin
                                    r_score <= r_score + 1'b1;
                                end
                            end else begin
                                r_crash  <= 1'b1;
                                r_res_ok <= 1'b0;
                            end
                        end
`ifdef LANDING_TIMEOUT_EN
                        else if (r_frame_cnt == FRAME_LAST) begin
                            r_crash   <= 1'b1;
                            r_res_ok  <= 1'b0;
                            r_res_cnt <= '0;
                            r_state   <= RESULT;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
`endif
                    end
                end

                RESULT: begin
                    if (w_tick) begin
                        if (r_res_cnt == RES_LAST) begin
                            r_res_cnt <= '0;
                            if (r_res_ok) begin
                                // Next round on the other pad.
                                r_target    <= ~r_target;
`ifdef LANDING_TIMEOUT_EN
                                r_frame_cnt <= '0;
`endif
                                r_state     <= ACTIVE;
                            end else begin
                                // Score stays visible until the next start.
                                r_state <= IDLE;
                            end
                        end else begin
                            r_res_cnt <= r_res_cnt + 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Pad enables (decoded from registered state only)
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves it unassigned (which would infer a latch).
        w_en1 = 1'b0;
        w_en2 = 1'b0;
        case (r_state)
            ACTIVE: begin
                w_en1 = ~r_target;
                w_en2 =  r_target;
            end
            RESULT: begin
                if (r_res_ok) begin
                    w_en1 = ~r_target & r_res_cnt[BLINK_SHIFT];
                    w_en2 =  r_target & r_res_cnt[BLINK_SHIFT];
                end
            end
            default: ;
        endcase
    end

    assign bus.landing1_enable = w_en1;
    assign bus.landing2_enable = w_en2;
    assign bus.target          = r_target;
    assign bus.success         = r_success;
    assign bus.crash           = r_crash;
    assign bus.busy            = (r_state != IDLE);
    assign bus.score           = r_score;

endmodule

// File: tb/tb_landing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_landing_ctrl
// Directed, self-checking bench for landing_ctrl. A frame is three clk cycles:
// vsync high for one cycle, then low for two. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// Status nibble compared throughout: {busy, landing1_enable, landing2_enable,
// target}. Pulse triple: {success after tick, crash after tick, any pulse one
// cycle later}.
// -----------------------------------------------------------------------------
module tb_landing_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    landing_ctrl_if bus ();

`ifdef LANDING_TIMEOUT_EN
    landing_ctrl #(.TIMEOUT_FRAMES(10)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    landing_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    logic f_succ;
    logic f_crash;
    logic f_late;

    logic [3:0] st;
    logic [2:0] pl;
    assign st = {bus.busy, bus.landing1_enable, bus.landing2_enable, bus.target};
    assign pl = {f_succ, f_crash, f_late};

    // One frame; captures the pulses in the cycle after the tick and the next.
    task automatic run_frame();
        @(negedge clk); bus.vsync_in = 1'b1;
        @(negedge clk); bus.vsync_in = 1'b0;
        f_succ  = bus.success;
        f_crash = bus.crash;
        @(negedge clk);
        f_late  = bus.success | bus.crash;
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic set_lander(input int x, input int y, input logic [7:0] vy);
        bus.lander_x  = 11'(x);
        bus.lander_y  = 11'(y);
        bus.lander_vy = vy;
    endtask

    task automatic test_reset();
        bus.vsync_in = 1'b0;
        bus.start    = 1'b0;
        set_lander(0, 300, 8'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (st !== 4'b0000) begin n_err++; $display("FAIL reset_status got=%b exp=0000", st); end
        n_vec++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
        n_vec++; if ({bus.success, bus.crash} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got=%b exp=00", {bus.success, bus.crash}); end
        rst = 1'b0;
        // A touch while IDLE must not be evaluated.
        set_lander(60, 560, 8'd3);
        run_frame();
        n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL idle_no_eval pulses got=%b exp=000", pl); end
        n_vec++; if (st !== 4'b0000) begin n_err++; $display("FAIL idle_status got=%b exp=0000", st); end
        set_lander(60, 300, 8'd3);
    endtask

    task automatic test_active();
        pulse_start();
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL start_status got=%b exp=1100", st); end
        for (int k = 1; k <= 3; k++) begin
            run_frame();
            n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL fly_pulses frame=%0d got=%b exp=000", k, pl); end
            n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL fly_status frame=%0d got=%b exp=1100", k, st); end
        end
    endtask

    task automatic test_success();
        logic [3:0] exp;
        set_lander(60, 560, 8'd3);
        run_frame();
        n_vec++; if (pl !== 3'b100) begin n_err++; $display("FAIL success_pulse got=%b exp=100", pl); end
        n_vec++; if (bus.score !== 8'd1) begin n_err++; $display("FAIL success_score got=%0d exp=1", bus.score); end
        n_vec++; if (st !== 4'b1000) begin n_err++; $display("FAIL success_status got=%b exp=1000", st); end
        set_lander(60, 300, 8'd3);
        // Pad 1 off for 8 frames, on for 8, ...; after 120 frames pad 2 round.
        for (int k = 1; k <= 120; k++) begin
            run_frame();
            exp = (k < 120) ? {1'b1, k[3], 2'b00} : 4'b1011;
            n_vec++; if (st !== exp) begin n_err++; $display("FAIL blink_status frame=%0d got=%b exp=%b", k, st, exp); end
            n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL blink_pulses frame=%0d got=%b exp=000", k, pl); end
        end
    endtask

    task automatic test_crash();
        logic [3:0] exp;
        set_lander(700, 560, 8'd5);
        run_frame();
        n_vec++; if (pl !== 3'b010) begin n_err++; $display("FAIL crash_pulse got=%b exp=010", pl); end
        n_vec++; if (st !== 4'b1001) begin n_err++; $display("FAIL crash_status got=%b exp=1001", st); end
        set_lander(700, 300, 8'd5);
        for (int k = 1; k <= 120; k++) begin
            run_frame();
            exp = (k < 120) ? 4'b1001 : 4'b0001;
            n_vec++; if (st !== exp) begin n_err++; $display("FAIL crash_result frame=%0d got=%b exp=%b", k, st, exp); end
        end
        n_vec++; if (bus.score !== 8'd1) begin n_err++; $display("FAIL crash_score_held got=%0d exp=1", bus.score); end
    endtask

    task automatic test_boundary_x();
        pulse_start();
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL restart_status got=%b exp=1100", st); end
        n_vec++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL restart_score got=%0d exp=0", bus.score); end
        // x = 125 is one past the right edge of pad 1.
        set_lander(125, 560, 8'd3);
        run_frame();
        n_vec++; if (pl !== 3'b010) begin n_err++; $display("FAIL x125_pulse got=%b exp=010", pl); end
        set_lander(125, 300, 8'd3);
        repeat (120) run_frame();
        n_vec++; if (st !== 4'b0000) begin n_err++; $display("FAIL x125_idle got=%b exp=0000", st); end
        pulse_start();
        // x = 124 is the last pixel of pad 1; vy = 4 is the speed limit.
        set_lander(124, 560, 8'd4);
        run_frame();
        n_vec++; if (pl !== 3'b100) begin n_err++; $display("FAIL x124_pulse got=%b exp=100", pl); end
        n_vec++; if (bus.score !== 8'd1) begin n_err++; $display("FAIL x124_score got=%0d exp=1", bus.score); end
        set_lander(124, 300, 8'd4);
        repeat (120) run_frame();
        n_vec++; if (st !== 4'b1011) begin n_err++; $display("FAIL pad2_round got=%b exp=1011", st); end
        // x = 744 is the last pixel of pad 2; vy = -1 (rising) is safe.
        set_lander(744, 560, 8'hFF);
        run_frame();
        n_vec++; if (pl !== 3'b100) begin n_err++; $display("FAIL x744_pulse got=%b exp=100", pl); end
        n_vec++; if (bus.score !== 8'd2) begin n_err++; $display("FAIL x744_score got=%0d exp=2", bus.score); end
        set_lander(744, 300, 8'd0);
        repeat (120) run_frame();
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL pad1_again got=%b exp=1100", st); end
    endtask

    task automatic test_start_ignored();
        pulse_start();
        run_frame();
        n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL start_active_pulses got=%b exp=000", pl); end
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL start_active_status got=%b exp=1100", st); end
        n_vec++; if (bus.score !== 8'd2) begin n_err++; $display("FAIL start_active_score got=%0d exp=2", bus.score); end
    endtask

    task automatic test_reset_mid();
        set_lander(10, 560, 8'd0);
        run_frame();
        n_vec++; if (pl !== 3'b100) begin n_err++; $display("FAIL x10_pulse got=%b exp=100", pl); end
        set_lander(10, 300, 8'd0);
        repeat (8) run_frame();
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL blink_on_before_rst got=%b exp=1100", st); end
        n_vec++; if (bus.score !== 8'd3) begin n_err++; $display("FAIL score_before_rst got=%0d exp=3", bus.score); end
        // Assert reset between clock edges; outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        n_vec++; if (st !== 4'b0000) begin n_err++; $display("FAIL async_rst_status got=%b exp=0000", st); end
        n_vec++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL async_rst_score got=%0d exp=0", bus.score); end
        @(negedge clk); rst = 1'b0;
        pulse_start();
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL start_after_rst got=%b exp=1100", st); end
        run_frame();
        n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL fly_after_rst got=%b exp=000", pl); end
    endtask

`ifdef LANDING_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        pulse_start();
        set_lander(60, 300, 8'd0);
        for (int k = 1; k <= 9; k++) begin
            run_frame();
            n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL pre_timeout frame=%0d got=%b exp=000", k, pl); end
        end
        run_frame();
        n_vec++; if (pl !== 3'b010) begin n_err++; $display("FAIL timeout_pulse got=%b exp=010", pl); end
        n_vec++; if (st !== 4'b1000) begin n_err++; $display("FAIL timeout_status got=%b exp=1000", st); end
        repeat (120) run_frame();
        n_vec++; if (st !== 4'b0000) begin n_err++; $display("FAIL timeout_idle got=%b exp=0000", st); end
        pulse_start();
        repeat (9) run_frame();
        // Touch on the timeout tick wins over the timeout.
        set_lander(60, 560, 8'd3);
        run_frame();
        n_vec++; if (pl !== 3'b100) begin n_err++; $display("FAIL touch_on_timeout got=%b exp=100", pl); end
        n_vec++; if (bus.score !== 8'd1) begin n_err++; $display("FAIL touch_on_timeout_score got=%0d exp=1", bus.score); end
    endtask
`else
    task automatic test_no_timeout();
        set_lander(60, 300, 8'd0);
        for (int k = 1; k <= 30; k++) begin
            run_frame();
            n_vec++; if (pl !== 3'b000) begin n_err++; $display("FAIL no_timeout frame=%0d got=%b exp=000", k, pl); end
        end
        n_vec++; if (st !== 4'b1100) begin n_err++; $display("FAIL no_timeout_status got=%b exp=1100", st); end
    endtask
`endif

    initial begin
        test_reset();
        test_active();
        test_success();
        test_crash();
        test_boundary_x();
        test_start_ignored();
        test_reset_mid();
`ifdef LANDING_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
